// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and load status for imem_loader.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start_load;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start_load, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  start_load, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a length-prefixed host byte stream into little-endian words for instruction memory.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte after the image.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_GET_LEN, S_COLLECT, S_WRITE, S_CHECK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_GET_LEN, S_COLLECT, S_WRITE} state_t;
`endif

  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

  state_t            state_reg, state_next;
  logic              in_ready_reg, in_ready_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [31:0]       wr_data_reg, wr_data_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [7:0]        len_reg, len_next;
  logic [7:0]        word_idx_reg, word_idx_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic [31:0]       shift_reg, shift_next;
  logic [31:0]       lane_word;
  logic              handshake;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  assign handshake = bus.in_valid & in_ready_reg;

  // Word as it would look with the incoming byte dropped into the current lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_word[gi*8 +: 8] = (byte_idx_reg == 2'(gi)) ? bus.in_data : shift_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    busy_next     = busy_reg;
    done_next     = done_reg;
    err_next      = err_reg;
    len_next      = len_reg;
    word_idx_next = word_idx_reg;
    byte_idx_next = byte_idx_reg;
    shift_next    = shift_reg;
`ifdef IMEM_LOADER_CSUM_EN
    csum_next     = csum_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (bus.start_load) begin
          state_next = S_GET_LEN;
          busy_next  = 1'b1;
          done_next  = 1'b0;
          err_next   = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_next  = 8'h00;
`endif
        end
      end

      S_GET_LEN: begin
        if (handshake) begin
          len_next = bus.in_data;
          if (bus.in_data == 8'h00) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_next = S_CHECK;
`else
            state_next = S_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
`endif
          end else if ({1'b0, bus.in_data} > DEPTH_LIM) begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end else begin
            state_next    = S_COLLECT;
            word_idx_next = 8'h00;
            byte_idx_next = 2'd0;
            shift_next    = 32'h0;
          end
        end
      end

      S_COLLECT: begin
        if (handshake) begin
          shift_next    = lane_word;
          byte_idx_next = byte_idx_reg + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_next     = csum_reg ^ bus.in_data;
`endif
          if (byte_idx_reg == 2'd3) begin
            state_next   = S_WRITE;
            wr_en_next   = 1'b1;
            wr_addr_next = word_idx_reg[ADDR_W-1:0];
            wr_data_next = lane_word;
          end
        end
      end

      S_WRITE: begin
        if (word_idx_reg == len_reg - 8'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
`endif
        end else begin
          state_next    = S_COLLECT;
          word_idx_next = word_idx_reg + 8'd1;
          byte_idx_next = 2'd0;
        end
      end

`ifdef IMEM_LOADER_CSUM_EN
      S_CHECK: begin
        if (handshake) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          err_next   = (bus.in_data != csum_reg);
        end
      end
`endif

      default: state_next = S_IDLE;
    endcase

    // in_ready is registered, so it is derived from the state being entered.
    in_ready_next = (state_next == S_GET_LEN) || (state_next == S_COLLECT);
`ifdef IMEM_LOADER_CSUM_EN
    if (state_next == S_CHECK) in_ready_next = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      in_ready_reg <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= 32'h0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      len_reg      <= 8'h00;
      word_idx_reg <= 8'h00;
      byte_idx_reg <= 2'd0;
      shift_reg    <= 32'h0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_reg     <= 8'h00;
`endif
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= in_ready_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      len_reg      <= len_next;
      word_idx_reg <= word_idx_next;
      byte_idx_reg <= byte_idx_next;
      shift_reg    <= shift_next;
`ifdef IMEM_LOADER_CSUM_EN
      csum_reg     <= csum_next;
`endif
    end
  end

  assign bus.in_ready = in_ready_reg;
  assign bus.wr_en    = wr_en_reg;
  assign bus.wr_addr  = wr_addr_reg;
  assign bus.wr_data  = wr_data_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two-word image, gaps/backpressure, oversize, zero length,
// reset mid-load, and the checksum byte when IMEM_LOADER_CSUM_EN is defined.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_cnt  = 0;
  int   base;
  logic [5:0]  wa_log [0:63];
  logic [31:0] wd_log [0:63];

  imem_loader_if #(.ADDR_W(6)) bus ();

  imem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Write log, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (wr_cnt < 64) begin
        wa_log[wr_cnt] = bus.wr_addr;
        wd_log[wr_cnt] = bus.wr_data;
      end
      $display("[TB] write #%0d addr=%0d data=%08h", wr_cnt, bus.wr_addr, bus.wr_data);
      wr_cnt = wr_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    bus.start_load = 1'b1;
    step();
    bus.start_load = 1'b0;
  endtask

  // Present a byte after 'gap' idle cycles and hold it until it is accepted.
  task automatic send(input logic [7:0] b, input int gap);
    logic hs;
    int   n;
    bus.in_valid = 1'b0;
    repeat (gap) step();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    do begin
      hs = bus.in_ready;
      step();
      n++;
    end while (!hs && n < 20);
    bus.in_valid = 1'b0;
    check($sformatf("handshake_%02h", b), {31'b0, hs}, 32'd1);
    $display("[TB] byte %02h accepted after %0d cycle(s)", b, n);
  endtask

  // Consume the end of an image: checksum byte when enabled, else one cycle after the last write.
  task automatic finish_load(input logic [7:0] cs);
`ifdef IMEM_LOADER_CSUM_EN
    send(cs, 0);
`else
    step();
`endif
  endtask

  task automatic check_two(input string tag, input int b);
    check({tag, "_nwrites"}, wr_cnt - b, 32'd2);
    check({tag, "_addr0"}, {26'b0, wa_log[b]}, 32'd0);
    check({tag, "_data0"}, wd_log[b], 32'h00500093);
    check({tag, "_addr1"}, {26'b0, wa_log[b+1]}, 32'd1);
    check({tag, "_data1"}, wd_log[b+1], 32'h00A00113);
  endtask

  task automatic load_std(input string tag, input logic [7:0] cs, input logic exp_err);
    start();
    check({tag, "_busy_start"}, {31'b0, bus.busy}, 32'd1);
    check({tag, "_ready_getlen"}, {31'b0, bus.in_ready}, 32'd1);
    send(8'h02, 0);
    send(8'h93, 0);
    send(8'h00, 0);
    send(8'h50, 0);
    send(8'h00, 0);
    check({tag, "_wr_en0"}, {31'b0, bus.wr_en}, 32'd1);
    check({tag, "_wr_addr0"}, {26'b0, bus.wr_addr}, 32'd0);
    check({tag, "_wr_data0"}, bus.wr_data, 32'h00500093);
    check({tag, "_ready_write"}, {31'b0, bus.in_ready}, 32'd0);
    send(8'h13, 0);
    send(8'h01, 0);
    send(8'hA0, 0);
    send(8'h00, 0);
    check({tag, "_wr_en1"}, {31'b0, bus.wr_en}, 32'd1);
    check({tag, "_wr_addr1"}, {26'b0, bus.wr_addr}, 32'd1);
    check({tag, "_wr_data1"}, bus.wr_data, 32'h00A00113);
    finish_load(cs);
    check({tag, "_done"}, {31'b0, bus.done}, 32'd1);
    check({tag, "_err"}, {31'b0, bus.err}, {31'b0, exp_err});
    check({tag, "_busy_end"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_wr_en_end"}, {31'b0, bus.wr_en}, 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
    check({tag, "_wr_en"}, {31'b0, bus.wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {26'b0, bus.wr_addr}, 32'd0);
    check({tag, "_wr_data"}, bus.wr_data, 32'd0);
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'b0, bus.done}, 32'd0);
    check({tag, "_err"}, {31'b0, bus.err}, 32'd0);
  endtask

  initial begin
    rst            = 1'b0;
    bus.start_load = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    step();
    step();
    check_reset("t1_reset");
    rst = 1'b1;
    step();

    // Two-word load.
    base = wr_cnt;
    load_std("t2", 8'h71, 1'b0);
    check_two("t2", base);

    // Gaps, a byte offered during WRITE, and start_load pulsed mid-load.
    base = wr_cnt;
    start();
    send(8'h02, 1);
    send(8'h93, 2);
    bus.start_load = 1'b1;
    send(8'h00, 0);
    bus.start_load = 1'b0;
    check("t3_busy_after_start", {31'b0, bus.busy}, 32'd1);
    send(8'h50, 3);
    send(8'h00, 0);
    check("t3_wr_en0", {31'b0, bus.wr_en}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h13;
    check("t3_ready_in_write", {31'b0, bus.in_ready}, 32'd0);
    step();
    check("t3_held_wr_en", {31'b0, bus.wr_en}, 32'd0);
    check("t3_held_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    send(8'h01, 2);
    send(8'hA0, 0);
    send(8'h00, 1);
    check("t3_wr_en1", {31'b0, bus.wr_en}, 32'd1);
    check("t3_wr_data1", bus.wr_data, 32'h00A00113);
    finish_load(8'h71);
    check("t3_done", {31'b0, bus.done}, 32'd1);
    check("t3_err", {31'b0, bus.err}, 32'd0);
    step();
    step();
    check("t3_idle_busy", {31'b0, bus.busy}, 32'd0);
    check("t3_idle_done", {31'b0, bus.done}, 32'd1);
    check_two("t3", base);

    // Oversize length.
    base = wr_cnt;
    start();
    check("t4_done_cleared", {31'b0, bus.done}, 32'd0);
    send(8'h41, 0);
    check("t4_err", {31'b0, bus.err}, 32'd1);
    check("t4_done", {31'b0, bus.done}, 32'd1);
    check("t4_busy", {31'b0, bus.busy}, 32'd0);
    check("t4_ready", {31'b0, bus.in_ready}, 32'd0);
    repeat (3) step();
    check("t4_nwrites", wr_cnt - base, 32'd0);

    // Zero length.
    base = wr_cnt;
    start();
    check("t4z_err_cleared", {31'b0, bus.err}, 32'd0);
    send(8'h00, 0);
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h00, 0);
`endif
    check("t4z_done", {31'b0, bus.done}, 32'd1);
    check("t4z_err", {31'b0, bus.err}, 32'd0);
    check("t4z_busy", {31'b0, bus.busy}, 32'd0);
    check("t4z_nwrites", wr_cnt - base, 32'd0);

    // Reset mid-load, then a clean load.
    base = wr_cnt;
    start();
    send(8'h02, 0);
    send(8'h93, 0);
    send(8'h00, 0);
    rst = 1'b0;
    step();
    step();
    check_reset("t5_reset");
    rst = 1'b1;
    step();
    check("t5_nwrites_before", wr_cnt - base, 32'd0);
    base = wr_cnt;
    load_std("t5", 8'h71, 1'b0);
    check_two("t5", base);

`ifdef IMEM_LOADER_CSUM_EN
    // Bad checksum: writes stand, image flagged.
    base = wr_cnt;
    load_std("t6_bad", 8'h70, 1'b1);
    check_two("t6_bad", base);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
